// File: rtl/fifo_dispatcher.sv
// fifo_dispatcher: routes one tagged input stream into NUM_REQS first-word-fall-through FIFOs.
// Each FIFO is popped independently. Out-of-range tags are accepted, dropped and flagged.
module fifo_dispatcher #(
   parameter int NUM_REQS = 4,
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int DWID     = $clog2(NUM_REQS),
   parameter int CWID     = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_vld,
   output logic                     in_rdy,
   input  logic [DWID-1:0]          in_dest,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [NUM_REQS-1:0]      pop,
   output logic [NUM_REQS*WIDTH-1:0] flat_data_out,
   output logic [NUM_REQS-1:0]      empty,
   output logic [NUM_REQS-1:0]      full,
   output logic [NUM_REQS*CWID-1:0] counts,
   output logic                     dest_err
);
   localparam int PW = $clog2(DEPTH);
   logic fire;
   logic dest_ok;
   logic rdy_sel;
   always_comb begin
      rdy_sel = 1'b1;
      dest_ok = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (in_dest == DWID'(i)) begin
            rdy_sel = ~full[i];
            dest_ok = 1'b1;
         end
      end
   end
   assign in_rdy = rst & rdy_sel;
   assign fire   = in_vld & in_rdy;
   always_ff @(posedge clk) begin
      if (!rst) dest_err <= 1'b0;
      else if (fire && !dest_ok) dest_err <= 1'b1;
   end
   for (genvar i = 0; i < NUM_REQS; i++) begin : g_fifo
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    wp;
      logic [PW-1:0]    rp;
      logic [CWID-1:0]  cnt;
      logic             wr;
      logic             rd;
      assign wr = fire & (in_dest == DWID'(i));
      assign rd = pop[i] & ~empty[i];
      // storage is deliberately not reset; emptiness masks stale contents
      always_ff @(posedge clk) begin
         if (wr) mem[wp] <= in_data;
      end
      always_ff @(posedge clk) begin
         if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
         end else begin
            if (wr) wp <= wp + PW'(1);
            if (rd) rp <= rp + PW'(1);
            cnt <= cnt + CWID'(wr) - CWID'(rd);
         end
      end
      assign empty[i] = (cnt == '0);
      assign full[i]  = (cnt == CWID'(DEPTH));
      assign counts[i*CWID +: CWID] = cnt;
      assign flat_data_out[i*WIDTH +: WIDTH] = empty[i] ? '0 : mem[rp];
   end
endmodule

// File: tb/tb_fifo_dispatcher.sv
// tb_fifo_dispatcher: directed checks of a 4-lane dispatcher and a 3-lane one (out-of-range tags).
module tb_fifo_dispatcher;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;

   logic        vld4 = 1'b0;
   logic        rdy4;
   logic [1:0]  dest4 = '0;
   logic [7:0]  data4 = '0;
   logic [3:0]  pop4 = '0;
   logic [31:0] flat4;
   logic [3:0]  empty4;
   logic [3:0]  full4;
   logic [11:0] counts4;
   logic        err4;

   logic        vld3 = 1'b0;
   logic        rdy3;
   logic [1:0]  dest3 = '0;
   logic [7:0]  data3 = '0;
   logic [2:0]  pop3 = '0;
   logic [23:0] flat3;
   logic [2:0]  empty3;
   logic [2:0]  full3;
   logic [8:0]  counts3;
   logic        err3;

   fifo_dispatcher u4 (
      .clk(clk), .rst(rst), .in_vld(vld4), .in_rdy(rdy4), .in_dest(dest4),
      .in_data(data4), .pop(pop4), .flat_data_out(flat4), .empty(empty4),
      .full(full4), .counts(counts4), .dest_err(err4)
   );

   fifo_dispatcher #(.NUM_REQS(3)) u3 (
      .clk(clk), .rst(rst), .in_vld(vld3), .in_rdy(rdy3), .in_dest(dest3),
      .in_data(data3), .pop(pop3), .flat_data_out(flat3), .empty(empty3),
      .full(full3), .counts(counts3), .dest_err(err3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push4(input logic [1:0] d, input logic [7:0] v);
      vld4 = 1'b1; dest4 = d; data4 = v;
      step();
      vld4 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      vld4 = 1'b1; dest4 = 2'd0;
      #1;
      checks++;
      if (rdy4 !== 1'b0) begin errors++; $display("FAIL rst_in_rdy got %b exp 0", rdy4); end
      step();
      step();
      vld4 = 1'b0;
      rst = 1'b1;
      repeat (5) step();
      checks++;
      if (empty4 !== 4'b1111) begin errors++; $display("FAIL reset_empty got %b exp 1111", empty4); end
      checks++;
      if (full4 !== 4'b0000) begin errors++; $display("FAIL reset_full got %b exp 0000", full4); end
      checks++;
      if (counts4 !== 12'h000) begin errors++; $display("FAIL reset_counts got %h exp 000", counts4); end
      checks++;
      if (err4 !== 1'b0) begin errors++; $display("FAIL reset_dest_err got %b exp 0", err4); end
      checks++;
      if (flat4 !== 32'h0) begin errors++; $display("FAIL reset_flat got %h exp 0", flat4); end
      checks++;
      if (empty3 !== 3'b111 || counts3 !== 9'h0 || err3 !== 1'b0) begin
         errors++; $display("FAIL reset_u3 got empty %b counts %h err %b exp 111 000 0", empty3, counts3, err3);
      end
      checks++;
      if (rdy4 !== 1'b1) begin errors++; $display("FAIL idle_in_rdy got %b exp 1", rdy4); end
   endtask

   task automatic test_single_route();
      push4(2'd2, 8'hA5);
      checks++;
      if (empty4 !== 4'b1011) begin errors++; $display("FAIL route_empty got %b exp 1011", empty4); end
      checks++;
      if (counts4 !== 12'h040) begin errors++; $display("FAIL route_counts got %h exp 040", counts4); end
      checks++;
      if (flat4 !== 32'h00A5_0000) begin errors++; $display("FAIL route_flat got %h exp 00a50000", flat4); end
      pop4 = 4'b0100;
      step();
      pop4 = 4'b0000;
      checks++;
      if (empty4 !== 4'b1111 || counts4 !== 12'h000) begin
         errors++; $display("FAIL route_pop got empty %b counts %h exp 1111 000", empty4, counts4);
      end
   endtask

   task automatic test_fill_wrap();
      logic [7:0] exp_q [4] = '{8'h12, 8'h13, 8'h14, 8'h15};
      for (int k = 0; k < 4; k++) push4(2'd1, 8'h10 + 8'(k));
      checks++;
      if (full4 !== 4'b0010 || counts4 !== 12'h020) begin
         errors++; $display("FAIL fill_full got full %b counts %h exp 0010 020", full4, counts4);
      end
      dest4 = 2'd1; #1;
      checks++;
      if (rdy4 !== 1'b0) begin errors++; $display("FAIL fill_rdy_d1 got %b exp 0", rdy4); end
      dest4 = 2'd0; #1;
      checks++;
      if (rdy4 !== 1'b1) begin errors++; $display("FAIL fill_rdy_d0 got %b exp 1", rdy4); end
      pop4 = 4'b0010;
      step();
      step();
      pop4 = 4'b0000;
      checks++;
      if (flat4[15:8] !== 8'h12 || counts4[5:3] !== 3'd2) begin
         errors++; $display("FAIL fill_after_pop got head %h count %0d exp 12 2", flat4[15:8], counts4[5:3]);
      end
      push4(2'd1, 8'h14);
      push4(2'd1, 8'h15);
      checks++;
      if (full4 !== 4'b0010) begin errors++; $display("FAIL wrap_full got %b exp 0010", full4); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (flat4[15:8] !== exp_q[k]) begin
            errors++; $display("FAIL drain_order[%0d] got %h exp %h", k, flat4[15:8], exp_q[k]);
         end
         pop4 = 4'b0010;
         step();
         pop4 = 4'b0000;
      end
      checks++;
      if (counts4 !== 12'h000 || empty4 !== 4'b1111) begin
         errors++; $display("FAIL drain_final got counts %h empty %b exp 000 1111", counts4, empty4);
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] exp_q [3] = '{8'h31, 8'h32, 8'h33};
      for (int k = 0; k < 4; k++) push4(2'd3, 8'h30 + 8'(k));
      checks++;
      if (full4[3] !== 1'b1) begin errors++; $display("FAIL fp_full got %b exp 1", full4[3]); end
      vld4 = 1'b1; dest4 = 2'd3; data4 = 8'h99; pop4 = 4'b1000;
      #1;
      checks++;
      if (rdy4 !== 1'b0) begin errors++; $display("FAIL fp_rdy got %b exp 0", rdy4); end
      step();
      vld4 = 1'b0; pop4 = 4'b0000;
      checks++;
      if (counts4[11:9] !== 3'd3 || full4 !== 4'b0000) begin
         errors++; $display("FAIL fp_after got count %0d full %b exp 3 0000", counts4[11:9], full4);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (flat4[31:24] !== exp_q[k]) begin
            errors++; $display("FAIL fp_order[%0d] got %h exp %h", k, flat4[31:24], exp_q[k]);
         end
         pop4 = 4'b1000;
         step();
         pop4 = 4'b0000;
      end
      checks++;
      if (empty4 !== 4'b1111) begin errors++; $display("FAIL fp_refused got empty %b exp 1111", empty4); end
   endtask

   task automatic test_concurrent();
      push4(2'd0, 8'h40);
      push4(2'd1, 8'h41);
      push4(2'd2, 8'h42);
      vld4 = 1'b1; dest4 = 2'd0; data4 = 8'h43; pop4 = 4'b1111;
      step();
      vld4 = 1'b0; pop4 = 4'b0000;
      checks++;
      if (counts4 !== 12'h001) begin errors++; $display("FAIL conc_counts got %h exp 001", counts4); end
      checks++;
      if (empty4 !== 4'b1110) begin errors++; $display("FAIL conc_empty got %b exp 1110", empty4); end
      checks++;
      if (flat4 !== 32'h0000_0043) begin errors++; $display("FAIL conc_flat got %h exp 00000043", flat4); end
      checks++;
      if (err4 !== 1'b0) begin errors++; $display("FAIL conc_err got %b exp 0", err4); end
      pop4 = 4'b0001;
      step();
      pop4 = 4'b0000;
   endtask

   task automatic test_out_of_range();
      vld3 = 1'b1; dest3 = 2'd0; data3 = 8'h55;
      step();
      dest3 = 2'd3; data3 = 8'h66;
      #1;
      checks++;
      if (rdy3 !== 1'b1) begin errors++; $display("FAIL oor_rdy got %b exp 1", rdy3); end
      step();
      vld3 = 1'b0;
      checks++;
      if (counts3 !== 9'h001 || flat3 !== 24'h000055) begin
         errors++; $display("FAIL oor_state got counts %h flat %h exp 001 000055", counts3, flat3);
      end
      checks++;
      if (err3 !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", err3); end
      repeat (3) step();
      checks++;
      if (err3 !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b exp 1", err3); end
      vld3 = 1'b1; dest3 = 2'd1; data3 = 8'h77;
      rst = 1'b0;
      step();
      vld3 = 1'b0;
      checks++;
      if (err3 !== 1'b0 || empty3 !== 3'b111 || counts3 !== 9'h0) begin
         errors++; $display("FAIL oor_reset got err %b empty %b counts %h exp 0 111 000", err3, empty3, counts3);
      end
      rst = 1'b1;
      step();
      checks++;
      if (empty3 !== 3'b111 || flat3 !== 24'h0) begin
         errors++; $display("FAIL oor_post got empty %b flat %h exp 111 000000", empty3, flat3);
      end
   endtask

   initial begin
      test_reset();
      test_single_route();
      test_fill_wrap();
      test_full_pop();
      test_concurrent();
      test_out_of_range();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_dispatcher.md
Name: fifo_dispatcher

Overview:
- Mirror of the arbitrated-FIFO merge path: takes one tagged input stream and demultiplexes it into NUM_REQS independent per-destination FIFOs, each drained by its own pop.
- Serves as the producer-side stimulus/fan-out stage in front of per-requestor consumers.
- Exposes per-FIFO empty/full/count status so a scoreboard can track any one lane.

Parameters:
NUM_REQS, 4, number of destination FIFOs (>=2)
WIDTH, 8, data width per entry
DEPTH, 4, entries per FIFO; power of two, >=2
DWID, $clog2(NUM_REQS), width of destination tag
CWID, $clog2(DEPTH)+1, width of each occupancy count

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset
in_vld  input  1  input word valid
in_rdy  output  1  dispatcher can accept the word on in_data/in_dest this cycle
in_dest  input  DWID  destination FIFO index
in_data  input  WIDTH  input word
pop  input  NUM_REQS  per-FIFO pop request
flat_data_out  output  NUM_REQS*WIDTH  head word of each FIFO; slice i = [(i+1)*WIDTH-1:i*WIDTH]
empty  output  NUM_REQS  FIFO i holds 0 entries
full  output  NUM_REQS  FIFO i holds DEPTH entries
counts  output  NUM_REQS*CWID  occupancy of each FIFO, same slicing rule
dest_err  output  1  sticky: out-of-range in_dest was accepted and dropped

Behaviour:
- Reset (rst==0 at posedge): all read/write pointers and counts = 0, so empty = all ones, full = 0, counts = 0, dest_err = 0, flat_data_out = 0.
- Storage is not cleared by reset. flat_data_out slice i is forced to 0 while empty[i].
- Reset mid-operation discards all queued data. in_rdy = 0 during the reset cycle.
- Accept condition: fire = in_vld & in_rdy.
  - If in_dest < NUM_REQS: in_rdy = ~full[in_dest].
  - If in_dest >= NUM_REQS (only possible when NUM_REQS is not a power of two): in_rdy = 1.
- in_rdy is combinational from in_dest and registered full. It has no combinational dependence on pop.
- Write on fire, valid dest: in_data written at wr_ptr[in_dest]; the pointer increments mod DEPTH (wrap via pointer width).
- Fire with out-of-range dest: word dropped, no FIFO changes, dest_err set to 1 and held until reset.
- Pop: when pop[i] & ~empty[i], rd_ptr[i] increments mod DEPTH. Pop on an empty FIFO is ignored, with no state change and no error.
- Latency:
  - First-word-fall-through: a word written at edge N is visible on flat_data_out slice i and empty[i] = 0 after edge N (cycle N+1).
  - Head data is read combinationally from storage at rd_ptr[i].
- Count update per FIFO: count[i] += (write to i) - (valid pop of i).
  - Simultaneous write and pop on the same FIFO: count unchanged, both pointers advance.
  - Allowed only when not full, since in_rdy already blocks the write when full.
  - Full plus pop in the same cycle: pop happens, write is refused, and full deasserts next cycle.
- Status derivation:
  - full[i] = (count[i] == DEPTH).
  - empty[i] = (count[i] == 0).
  - All status is registered-derived, never from same-cycle inputs.
- Ordering: per-destination FIFO order is preserved exactly. There is no ordering relation across destinations.
- Only one FIFO is written per cycle. Any subset of FIFOs may pop in the same cycle.
- in_vld = 0: in_rdy still reflects ~full[in_dest], but no write occurs.

Test Plan:
- Reset then idle: release rst, hold in_vld = 0 for 5 cycles -> empty = 4'b1111, full = 0, all counts = 0, dest_err = 0, flat_data_out = 0.
- Single route: send 0xA5 with dest = 2 -> next cycle empty = 4'b1011, counts[2] = 1, slice 2 = 0xA5. pop[2] -> next cycle empty[2] = 1, count 0.
- Fill and wrap: push 0x10..0x13 to dest 1 -> full[1] = 1 and in_rdy = 0 for dest 1, while dest 0 is still in_rdy = 1.
  - Pop twice, push 0x14, 0x15.
  - Drain -> output order 0x12, 0x13, 0x14, 0x15; counts return to 0.
- Full with simultaneous pop: dest 3 full, in_vld with dest = 3 and pop[3] in the same cycle -> in_rdy = 0, write refused, count[3] goes 4 to 3, full[3] = 0 next cycle.
- Concurrent traffic: push to dest 0 while popping FIFOs 0, 1 and 2 (each holding 1 entry) -> count[0] stays 1 with the new head, FIFOs 1 and 2 go empty. Pop of empty FIFO 3 is ignored.
- Out-of-range dest (NUM_REQS = 3, DWID = 2): fire with in_dest = 3 -> in_rdy = 1, all counts unchanged, dest_err = 1 until the next reset. Reset asserted mid-stream clears it and empties all FIFOs.
